// File: rtl/pllcfg_seq.sv
// pllcfg_seq: host-side PLL reconfiguration sequencer (PLL reset, lock wait, CPU handshake, lock check).
// Optional sticky lock-loss monitor is compiled in when PLLCFG_SEQ_LOCKMON_EN is defined.
module pllcfg_seq #(
  parameter int N_PLL   = 6,
  parameter int RST_CYC = 16,
  parameter int LOCK_TO = 65535,
  parameter int ACK_TO  = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_start,
  input  logic [1:0]       cmd_type,
  input  logic [2:0]       cmd_ind,
  input  logic             cmd_abort,
  output logic [3:0]       cpu_cmd,
  input  logic [7:0]       cpu_stat,
  output logic [N_PLL-1:0] pll_rst,
  input  logic [N_PLL-1:0] pll_lock,
`ifdef PLLCFG_SEQ_LOCKMON_EN
  output logic [N_PLL-1:0] lock_lost,
  input  logic             lock_lost_clr,
`endif
  output logic             seq_busy,
  output logic             seq_done,
  output logic [2:0]       seq_err
);
  localparam int CMAX = (LOCK_TO > ACK_TO) ? ((LOCK_TO > RST_CYC) ? LOCK_TO : RST_CYC)
                                           : ((ACK_TO > RST_CYC) ? ACK_TO : RST_CYC);
  localparam int CW = $clog2(CMAX + 1);

  typedef enum logic [2:0] {IDLE, RST, LOCKW, CPU_REQ, CPU_WAIT, LOCKC, DONE} state_t;

  state_t           state;
  logic [N_PLL-1:0] lock_s1, lock_s2, sel;
  logic [2:0]       stat_q;
  logic [1:0]       typ;
  logic [CW-1:0]    cnt;
  logic             sel_lock, bad_cmd, fin, unused_stat;
  logic [2:0]       fin_err;

  // sel is one-hot, so an out-of-range index selects nothing
  assign sel_lock    = |(lock_s2 & sel);
  assign bad_cmd     = (32'(cmd_ind) >= N_PLL) || (cmd_type == 2'd3);
  assign unused_stat = ^cpu_stat[7:3];

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_s1 <= '0;
      lock_s2 <= '0;
      stat_q  <= '0;
    end else begin
      lock_s1 <= pll_lock;
      lock_s2 <= lock_s1;
      stat_q  <= cpu_stat[2:0];
    end
  end

  // Every path into DONE funnels through fin/fin_err; abort overrides any state's own outcome.
  always_comb begin
    fin     = 1'b0;
    fin_err = 3'd0;
    case (state)
      LOCKW:
        if (sel_lock) fin = (typ == 2'd2);
        else if (cnt == CW'(LOCK_TO - 1)) begin fin = 1'b1; fin_err = 3'd1; end
      CPU_REQ:
        if (!stat_q[0] && cnt == CW'(ACK_TO - 1)) begin fin = 1'b1; fin_err = 3'd2; end
      CPU_WAIT:
        if (stat_q[2]) begin fin = 1'b1; fin_err = 3'd3; end
      LOCKC: begin
        fin     = 1'b1;
        fin_err = sel_lock ? 3'd0 : 3'd1;
      end
      default: ;
    endcase
    if (cmd_abort && state != IDLE && state != DONE) begin
      fin     = 1'b1;
      fin_err = 3'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cpu_cmd  <= '0;
      pll_rst  <= '0;
      seq_busy <= 1'b0;
      seq_done <= 1'b0;
      seq_err  <= '0;
      sel      <= '0;
      typ      <= '0;
      cnt      <= '0;
    end else if (fin) begin
      state    <= DONE;
      seq_err  <= fin_err;
      seq_done <= 1'b1;
      seq_busy <= 1'b0;
      cpu_cmd  <= {fin_err == 3'd4, 3'b000};
      pll_rst  <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE:
          if (cmd_start) begin
            typ <= cmd_type;
            sel <= N_PLL'(1) << cmd_ind;
            if (bad_cmd) begin
              seq_err  <= 3'd5;
              seq_done <= 1'b1;
            end else begin
              seq_err  <= 3'd0;
              seq_done <= 1'b0;
              seq_busy <= 1'b1;
              pll_rst  <= N_PLL'(1) << cmd_ind;
              cnt      <= '0;
              state    <= RST;
            end
          end
        RST:
          if (cnt == CW'(RST_CYC - 1)) begin
            pll_rst <= '0;
            cnt     <= '0;
            state   <= LOCKW;
          end else cnt <= cnt + 1'b1;
        LOCKW:
          if (sel_lock) begin
            cpu_cmd <= {1'b0, typ, 1'b1};
            cnt     <= '0;
            state   <= CPU_REQ;
          end else cnt <= cnt + 1'b1;
        CPU_REQ:
          if (stat_q[0]) begin
            cpu_cmd[0] <= 1'b0;
            state      <= CPU_WAIT;
          end else cnt <= cnt + 1'b1;
        CPU_WAIT:
          if (stat_q[1]) state <= LOCKC;
        DONE: begin
          cpu_cmd <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PLLCFG_SEQ_LOCKMON_EN
  logic [N_PLL-1:0] lock_prev, lost_set;

  // The PLL being sequenced is expected to drop lock, so it is masked while busy.
  assign lost_set = lock_prev & ~lock_s2 & ~(seq_busy ? sel : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_prev <= '0;
      lock_lost <= '0;
    end else begin
      lock_prev <= lock_s2;
      lock_lost <= (lock_lost_clr ? '0 : lock_lost) | lost_set;
    end
  end
`endif
endmodule

// File: tb/tb_pllcfg_seq.sv
// Randomized self-checking bench for pllcfg_seq: behavioural PLL/CPU responders plus outcome model.
module tb_pllcfg_seq;
  localparam int N_PLL = 6, RST_CYC = 16, LOCK_TO = 100, ACK_TO = 50;

  logic             clk = 1'b0, rst = 1'b1, cmd_start = 1'b0, cmd_abort = 1'b0;
  logic [1:0]       cmd_type = '0;
  logic [2:0]       cmd_ind = '0;
  logic [3:0]       cpu_cmd;
  logic [7:0]       cpu_stat = '0;
  logic [N_PLL-1:0] pll_rst;
  logic [N_PLL-1:0] pll_lock = '1;
  logic             seq_busy, seq_done;
  logic [2:0]       seq_err;
  int               n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  pllcfg_seq #(.N_PLL(N_PLL), .RST_CYC(RST_CYC), .LOCK_TO(LOCK_TO), .ACK_TO(ACK_TO)) dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_type(cmd_type), .cmd_ind(cmd_ind),
    .cmd_abort(cmd_abort), .cpu_cmd(cpu_cmd), .cpu_stat(cpu_stat), .pll_rst(pll_rst),
    .pll_lock(pll_lock), .seq_busy(seq_busy), .seq_done(seq_done), .seq_err(seq_err));

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // lock_dly/ack_dly < 0: never happens. cpu_res: 0 done, 1 err, 2 done but lock lost first.
  // abort_at > 0: abort on that sample; < 0: abort 10 cycles into the CPU operation.
  task automatic run_seq(input logic [1:0] typ, input logic [2:0] ind, input int lock_dly,
                         input int ack_dly, input int cpu_len, input int cpu_res, input int abort_at);
    bit good, lock_ok, req_exp, abort_eff, fin, busy_seen, other_rst, busy_up, cpu_fin;
    int cyc, post, rst_len, req_len, wait_len, abort_len, since_rel, since_req, cpu_cnt, exp_err, exp_req;
    logic [N_PLL-1:0] mask;
    good      = (typ != 2'd3) && (ind < N_PLL);
    mask      = good ? (N_PLL'(1) << ind) : '0;
    lock_ok   = lock_dly >= 0;
    req_exp   = good && lock_ok && typ != 2'd2 && abort_at <= 0;
    abort_eff = good && (abort_at > 0 || (abort_at < 0 && req_exp && ack_dly >= 0));
    if (!good)                exp_err = 5;
    else if (abort_eff)       exp_err = 4;
    else if (!lock_ok)        exp_err = 1;
    else if (typ == 2'd2)     exp_err = 0;
    else if (ack_dly < 0)     exp_err = 2;
    else if (cpu_res == 1)    exp_err = 3;
    else if (cpu_res == 2)    exp_err = 1;
    else                      exp_err = 0;
    exp_req = !req_exp ? 0 : (ack_dly < 0 ? ACK_TO : ack_dly + 1);
    {fin, busy_seen, other_rst, busy_up, cpu_fin} = '0;
    {cyc, post, rst_len, req_len, wait_len, abort_len, since_rel, since_req, cpu_cnt} = '0;

    @(negedge clk); cmd_type = typ; cmd_ind = ind; cmd_start = 1'b1;
    @(negedge clk); cmd_start = 1'b0;
    while (post < 3 && cyc < 2000) begin
      cyc++;
      cmd_start = 1'b0;
      cmd_abort = 1'b0;
      if (seq_busy) busy_seen = 1'b1;
      if (|(pll_rst & ~mask)) other_rst = 1'b1;
      if (cpu_cmd[3]) abort_len++;
      if (cpu_cmd[0]) req_len++;
      if (seq_busy && rst_len > 0 && pll_rst == '0 && req_len == 0) wait_len++;
      if (abort_at > 0 && cyc == abort_at) cmd_abort = 1'b1;
      if (good) begin
        if (pll_rst[ind]) begin
          rst_len++;
          pll_lock[ind] = 1'b0;
        end else if (rst_len > 0) begin
          since_rel++;
          if (lock_dly >= 0 && since_rel == lock_dly) pll_lock[ind] = 1'b1;
        end
        if (cpu_cmd[0]) begin
          since_req++;
          if (ack_dly >= 0 && since_req == ack_dly) begin
            cpu_stat = {5'($urandom), 3'b001};
            busy_up  = 1'b1;
          end
        end
        if (busy_up && !cpu_fin) begin
          cpu_cnt++;
          if (abort_at < 0 && cpu_cnt == 10) cmd_abort = 1'b1;
          else if (abort_at >= 0) begin
            if (cpu_res == 2 && cpu_cnt == cpu_len - 5) pll_lock[ind] = 1'b0;
            if (cpu_cnt == cpu_len) begin
              cpu_stat = {5'($urandom), (cpu_res == 1) ? 3'b100 : 3'b010};
              cpu_fin  = 1'b1;
            end
          end
        end
        // a second start while busy must be dropped
        if (cyc == 3) begin
          cmd_start = 1'b1;
          cmd_ind   = 3'((ind + 1) % N_PLL);
          cmd_type  = 2'd0;
        end
      end
      if (seq_done) fin = 1'b1;
      if (fin) post++;
      @(negedge clk);
    end
    cmd_start = 1'b0;
    cmd_abort = 1'b0;
    chk("finished", int'(fin), 1);
    chk("seq_err", int'(seq_err), exp_err);
    chk("seq_done", int'(seq_done), 1);
    chk("busy_end", int'(seq_busy), 0);
    chk("busy_seen", int'(busy_seen), int'(good));
    chk("other_rst", int'(other_rst), 0);
    if (good && abort_at <= 0) chk("rst_len", rst_len, RST_CYC);
    chk("req_len", req_len, exp_req);
    chk("abort_len", abort_len, int'(abort_eff));
    if (good && !lock_ok && abort_at == 0) chk("lockw_len", wait_len, LOCK_TO);
    chk("cpu_cmd_end", int'(cpu_cmd), 0);
    pll_lock = '1;
    cpu_stat = '0;
    repeat (4) @(negedge clk);
    chk("err_sticky", int'(seq_err), exp_err);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cpu_cmd", int'(cpu_cmd), 0);
    chk("rst_pll_rst", int'(pll_rst), 0);
    chk("rst_busy", int'(seq_busy), 0);
    chk("rst_done", int'(seq_done), 0);
    chk("rst_err", int'(seq_err), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_seq(2'd0, 3'd2, 10, 5, 100, 0, 0);   // reconfig pass
    run_seq(2'd0, 3'd3, -1, 5, 20, 0, 0);    // lock timeout
    run_seq(2'd1, 3'd0, 8, -1, 20, 0, 0);    // CPU ack timeout
    run_seq(2'd0, 3'd7, 10, 5, 20, 0, 2);    // bad index, abort in IDLE ignored
    run_seq(2'd3, 3'd1, 10, 5, 20, 0, 0);    // reserved type
    run_seq(2'd0, 3'd4, 6, 3, 50, 0, -1);    // abort in CPU_WAIT
    run_seq(2'd2, 3'd5, 12, 5, 20, 0, 0);    // reset only
    run_seq(2'd1, 3'd1, 5, 4, 30, 1, 0);     // CPU error
    run_seq(2'd0, 3'd0, 5, 4, 30, 2, 0);     // lock lost before final check
    run_seq(2'd0, 3'd3, 5, 5, 20, 0, 6);     // abort in RST

    for (int i = 0; i < 30; i++) begin
      int ld, ad, ab;
      ld = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(1, 60));
      ad = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(1, 45));
      case ($urandom_range(0, 7))
        0:       ab = int'($urandom_range(2, 12));
        1:       ab = -1;
        default: ab = 0;
      endcase
      run_seq(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), ld, ad,
              int'($urandom_range(10, 80)), int'($urandom_range(0, 2)), ab);
    end

    // synchronous reset in the middle of the PLL reset phase
    @(negedge clk); cmd_type = 2'd2; cmd_ind = 3'd1; cmd_start = 1'b1;
    @(negedge clk); cmd_start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", int'(seq_busy), 1);
    chk("pre_rst_pll", int'(pll_rst), 2);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("midrst_pll", int'(pll_rst), 0);
    chk("midrst_busy", int'(seq_busy), 0);
    chk("midrst_done", int'(seq_done), 0);
    chk("midrst_err", int'(seq_err), 0);
    chk("midrst_cmd", int'(cpu_cmd), 0);
    repeat (5) @(negedge clk);
    chk("midrst_idle", int'(seq_busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
